// File: rtl/axi_apb_rd_bridge.sv
// AXI read-slave to APB read-master bridge.
// One APB read per AXI beat, single outstanding burst, 32-bit data path.
module axi_apb_rd_bridge #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    // AXI read-address channel
    input  logic              arvalid,
    output logic              arready,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [LEN_W-1:0]  arlen,
    input  logic [1:0]        arburst,
    // AXI read-data channel
    output logic              rvalid,
    input  logic              rready,
    output logic [ID_W-1:0]   rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    // APB master
    output logic              psel,
    output logic              penable,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    input  logic [31:0]       prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [1:0]          burst_q, burst_d;
    logic [LEN_W-1:0]    beat_q, beat_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;

    logic                last_beat;
    logic                wrap_ok;
    logic [ADDR_W-1:0]   wrap_mask;
    logic [ADDR_W-1:0]   addr_inc;
    logic [ADDR_W-1:0]   addr_next;

    assign last_beat = (beat_q == len_q);

    // Next beat address: FIXED holds, legal WRAP wraps, everything else increments.
    always_comb begin
        addr_inc  = addr_q + ADDR_W'(4);
        wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << 2) - ADDR_W'(1);
        wrap_ok   = (burst_q == 2'b10) &&
                    ((len_q == LEN_W'(1)) || (len_q == LEN_W'(3)) ||
                     (len_q == LEN_W'(7)) || (len_q == LEN_W'(15)));
        if (burst_q == 2'b00) begin
            addr_next = addr_q;
        end else if (wrap_ok) begin
            addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
        end else begin
            addr_next = addr_inc;
        end
    end

    // FSM next-state and datapath next values.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        unique case (state_q)
            StIdle: begin
                if (arvalid) begin
                    id_d    = arid;
                    addr_d  = araddr;
                    len_d   = arlen;
                    burst_d = arburst;
                    beat_d  = '0;
                    state_d = StSetup;
                end
            end
            StSetup: state_d = StAccess;
            StAccess: begin
                if (pready) begin
                    rdata_d = prdata;
                    rresp_d = pslverr ? 2'b10 : 2'b00;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rready) begin
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        beat_d  = beat_q + LEN_W'(1);
                        addr_d  = addr_next;
                        state_d = StSetup;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-high reset; a burst in flight is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            rdata_q <= '0;
            rresp_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
        end
    end

    // Outputs decode straight from registers; arready is masked while reset is held.
    assign arready = (state_q == StIdle) && !rst;
    assign psel    = (state_q == StSetup) || (state_q == StAccess);
    assign penable = (state_q == StAccess);
    assign paddr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign pwrite  = 1'b0;
    assign rvalid  = (state_q == StResp);
    assign rlast   = (state_q == StResp) && last_beat;
    assign rid     = id_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_apb_rd_bridge.sv
// Directed self-checking bench for axi_apb_rd_bridge.
module tb_axi_apb_rd_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int checks = 0;
    int errors = 0;

    axi_apb_rd_bridge #(.ID_W(4), .ADDR_W(32), .LEN_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .arvalid (arvalid),
        .arready (arready),
        .arid    (arid),
        .araddr  (araddr),
        .arlen   (arlen),
        .arburst (arburst),
        .rvalid  (rvalid),
        .rready  (rready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .psel    (psel),
        .penable (penable),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an AR request in IDLE and complete the handshake.
    task automatic ar(input logic [3:0] id, input logic [31:0] addr,
                      input logic [7:0] len, input logic [1:0] burst);
        arvalid = 1'b1;
        arid    = id;
        araddr  = addr;
        arlen   = len;
        arburst = burst;
        #1;
        check("arready_idle", {63'd0, arready}, 64'd1);
        tick();
        arvalid = 1'b0;
        arid    = 4'hF;
        araddr  = 32'hA5A5A5A5;
        arlen   = 8'hFF;
        arburst = 2'b11;
    endtask

    // Walk one APB read (SETUP, waits, ACCESS completion); ends with the DUT in RESP.
    task automatic apb_beat(input logic [31:0] exp_paddr, input logic [31:0] data,
                            input logic err, input int waits);
        check("setup_psel", {63'd0, psel}, 64'd1);
        check("setup_penable", {63'd0, penable}, 64'd0);
        check("setup_paddr", {32'd0, paddr}, {32'd0, exp_paddr});
        check("setup_arready", {63'd0, arready}, 64'd0);
        check("setup_pwrite", {63'd0, pwrite}, 64'd0);
        tick();
        for (int w = 0; w < waits; w++) begin
            pready  = 1'b0;
            pslverr = 1'b1;
            #1;
            check("wait_psel", {63'd0, psel}, 64'd1);
            check("wait_penable", {63'd0, penable}, 64'd1);
            check("wait_paddr", {32'd0, paddr}, {32'd0, exp_paddr});
            check("wait_rvalid", {63'd0, rvalid}, 64'd0);
            tick();
        end
        pready  = 1'b1;
        prdata  = data;
        pslverr = err;
        #1;
        check("access_penable", {63'd0, penable}, 64'd1);
        check("access_paddr", {32'd0, paddr}, {32'd0, exp_paddr});
        check("access_rvalid", {63'd0, rvalid}, 64'd0);
        tick();
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h0BAD0BAD;
    endtask

    // Check an R beat, optionally stall rready, then handshake.
    task automatic r_beat(input logic [3:0] exp_id, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input logic exp_last, input int stall);
        for (int s = 0; s <= stall; s++) begin
            rready = 1'b0;
            #1;
            check("r_rvalid", {63'd0, rvalid}, 64'd1);
            check("r_rid", {60'd0, rid}, {60'd0, exp_id});
            check("r_rdata", {32'd0, rdata}, {32'd0, exp_data});
            check("r_rresp", {62'd0, rresp}, {62'd0, exp_resp});
            check("r_rlast", {63'd0, rlast}, {63'd0, exp_last});
            check("r_psel", {63'd0, psel}, 64'd0);
            check("r_penable", {63'd0, penable}, 64'd0);
            if (s < stall) tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        arvalid = 1'b0;
        arid    = '0;
        araddr  = '0;
        arlen   = '0;
        arburst = '0;
        rready  = 1'b0;
        prdata  = '0;
        pready  = 1'b0;
        pslverr = 1'b0;
        tick();
        tick();
        check("rst_arready", {63'd0, arready}, 64'd0);
        check("rst_rvalid", {63'd0, rvalid}, 64'd0);
        check("rst_psel", {63'd0, psel}, 64'd0);
        check("rst_penable", {63'd0, penable}, 64'd0);
        check("rst_rlast", {63'd0, rlast}, 64'd0);
        check("rst_rid", {60'd0, rid}, 64'd0);
        check("rst_rdata", {32'd0, rdata}, 64'd0);
        check("rst_rresp", {62'd0, rresp}, 64'd0);
        check("rst_paddr", {32'd0, paddr}, 64'd0);
        rst = 1'b0;
        tick();

        // Single beat: rvalid three edges after the AR handshake.
        ar(4'd3, 32'h100, 8'd0, 2'b01);
        apb_beat(32'h100, 32'hDEADBEEF, 1'b0, 0);
        r_beat(4'd3, 32'hDEADBEEF, 2'b00, 1'b1, 0);
        check("single_done_arready", {63'd0, arready}, 64'd1);

        // INCR crossing 0x200, with a 5-cycle R stall on beat 2.
        ar(4'd7, 32'h1F8, 8'd3, 2'b01);
        apb_beat(32'h1F8, 32'h11110000, 1'b0, 0);
        r_beat(4'd7, 32'h11110000, 2'b00, 1'b0, 0);
        apb_beat(32'h1FC, 32'h22220001, 1'b0, 0);
        r_beat(4'd7, 32'h22220001, 2'b00, 1'b0, 5);
        apb_beat(32'h200, 32'h33330002, 1'b0, 0);
        r_beat(4'd7, 32'h33330002, 2'b00, 1'b0, 0);
        apb_beat(32'h204, 32'h44440003, 1'b0, 0);
        r_beat(4'd7, 32'h44440003, 2'b00, 1'b1, 0);
        check("incr_done_arready", {63'd0, arready}, 64'd1);

        // WRAP 4 beats from 0x3C wraps within 0x30..0x3F.
        ar(4'd2, 32'h3C, 8'd3, 2'b10);
        apb_beat(32'h3C, 32'hA0, 1'b0, 0);
        r_beat(4'd2, 32'hA0, 2'b00, 1'b0, 0);
        apb_beat(32'h30, 32'hA1, 1'b0, 0);
        r_beat(4'd2, 32'hA1, 2'b00, 1'b0, 0);
        apb_beat(32'h34, 32'hA2, 1'b0, 0);
        r_beat(4'd2, 32'hA2, 2'b00, 1'b0, 0);
        apb_beat(32'h38, 32'hA3, 1'b0, 0);
        r_beat(4'd2, 32'hA3, 2'b00, 1'b1, 0);

        // FIXED 3 beats all at 0x40.
        ar(4'd9, 32'h40, 8'd2, 2'b00);
        apb_beat(32'h40, 32'hF0, 1'b0, 0);
        r_beat(4'd9, 32'hF0, 2'b00, 1'b0, 0);
        apb_beat(32'h40, 32'hF1, 1'b0, 0);
        r_beat(4'd9, 32'hF1, 2'b00, 1'b0, 0);
        apb_beat(32'h40, 32'hF2, 1'b0, 0);
        r_beat(4'd9, 32'hF2, 2'b00, 1'b1, 0);

        // Wait states and slave error on beat 1 only.
        ar(4'd4, 32'h10, 8'd1, 2'b01);
        apb_beat(32'h10, 32'hE0E0E0E0, 1'b1, 4);
        r_beat(4'd4, 32'hE0E0E0E0, 2'b10, 1'b0, 0);
        apb_beat(32'h14, 32'hE1E1E1E1, 1'b0, 0);
        r_beat(4'd4, 32'hE1E1E1E1, 2'b00, 1'b1, 0);
        check("err_done_arready", {63'd0, arready}, 64'd1);

        // Reset during ACCESS of beat 2 of 4.
        ar(4'd6, 32'h80, 8'd3, 2'b01);
        apb_beat(32'h80, 32'h600D0001, 1'b0, 0);
        r_beat(4'd6, 32'h600D0001, 2'b00, 1'b0, 0);
        check("mid_setup_psel", {63'd0, psel}, 64'd1);
        tick();
        check("mid_access_penable", {63'd0, penable}, 64'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_psel", {63'd0, psel}, 64'd0);
        check("mid_rst_penable", {63'd0, penable}, 64'd0);
        check("mid_rst_rvalid", {63'd0, rvalid}, 64'd0);
        check("mid_rst_arready", {63'd0, arready}, 64'd0);
        check("mid_rst_rid", {60'd0, rid}, 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_arready", {63'd0, arready}, 64'd1);
        tick();
        check("post_rst_rvalid", {63'd0, rvalid}, 64'd0);
        ar(4'd5, 32'h20, 8'd0, 2'b01);
        apb_beat(32'h20, 32'h5A5A5A5A, 1'b0, 0);
        r_beat(4'd5, 32'h5A5A5A5A, 2'b00, 1'b1, 0);

        // Unaligned start address drops the low bits.
        ar(4'd1, 32'h103, 8'd0, 2'b01);
        apb_beat(32'h100, 32'h12345678, 1'b0, 0);
        r_beat(4'd1, 32'h12345678, 2'b00, 1'b1, 0);

        // INCR wraps modulo 2^32.
        ar(4'd8, 32'hFFFFFFFC, 8'd1, 2'b01);
        apb_beat(32'hFFFFFFFC, 32'hCAFE0000, 1'b0, 0);
        r_beat(4'd8, 32'hCAFE0000, 2'b00, 1'b0, 0);
        apb_beat(32'h00000000, 32'hCAFE0001, 1'b0, 0);
        r_beat(4'd8, 32'hCAFE0001, 2'b00, 1'b1, 0);

        // WRAP with an illegal length behaves as INCR.
        ar(4'd10, 32'h3C, 8'd2, 2'b10);
        apb_beat(32'h3C, 32'hB0, 1'b0, 0);
        r_beat(4'd10, 32'hB0, 2'b00, 1'b0, 0);
        apb_beat(32'h40, 32'hB1, 1'b0, 0);
        r_beat(4'd10, 32'hB1, 2'b00, 1'b0, 0);
        apb_beat(32'h44, 32'hB2, 1'b0, 0);
        r_beat(4'd10, 32'hB2, 2'b00, 1'b1, 0);
        check("final_arready", {63'd0, arready}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_apb_rd_bridge.md
Name: axi_apb_rd_bridge

Overview:
- AXI read-slave to APB-master bridge. Consumes the AXI read-address channel from an upstream AXI master and returns read data on the AXI R channel.
- Each AXI beat becomes one APB read transfer to the downstream APB slave (register block).
- Single outstanding transaction. Fixed 32-bit data path, bursts supported.

Parameters:
ID_W, 4, AXI ID width (arid/rid)
ADDR_W, 32, address width (araddr/paddr)
LEN_W, 8, AXI burst-length field width (beats = arlen+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
arvalid  in  1  read address valid
arready  out  1  read address ready
arid  in  ID_W  transaction ID
araddr  in  ADDR_W  start byte address
arlen  in  LEN_W  beats-1
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
rvalid  out  1  read data valid
rready  in  1  read data ready
rid  out  ID_W  echo of latched arid
rdata  out  32  captured prdata
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  final beat of burst
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  ADDR_W  APB address, word-aligned
pwrite  out  1  constant 0
prdata  in  32  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Reset: clk rising edge with rst=1 forces state=IDLE. Outputs while rst=1: arready=0, rvalid=0, rlast=0, psel=0, penable=0, pwrite=0, rresp=0, rid=0, rdata=0, paddr=0.
- A transaction in flight when rst asserts is discarded. psel drops at the next edge and no R beat is produced.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - arready=1 (only state where it is 1).
  - On arvalid&&arready: latch id, addr, len, burst; clear beat counter; go to SETUP.
- SETUP:
  - psel=1, penable=0.
  - paddr = {addr[ADDR_W-1:2],2'b00}; low address bits are ignored.
  - Always go to ACCESS next cycle.
- ACCESS:
  - psel=1, penable=1, paddr held.
  - Stay while pready=0; there is no timeout.
  - On pready=1: capture prdata into rdata and rresp = pslverr ? 2'b10 : 2'b00; go to RESP.
- RESP:
  - rvalid=1, rid=latched id, rlast=(beat==len); psel=0, penable=0.
  - rdata, rresp, rid, rlast are held stable while rvalid=1 && rready=0.
  - On rready=1 with rlast=1: go to IDLE.
  - On rready=1 with rlast=0: beat+=1, update addr, go to SETUP.
- Latency: AR handshake at edge N; psel at N+1; penable at N+2. With pready=1 at N+2, rvalid is 1 at N+3. Each further beat costs a minimum of 3 cycles; there is no back-to-back APB.
- Address update, applied per beat after the R handshake:
  - FIXED: addr unchanged.
  - INCR: addr+4, modulo 2^ADDR_W; no 4KB-boundary check.
  - WRAP with len in {1,3,7,15}: mask=((len+1)*4)-1; next = (addr & ~mask) | ((addr+4) & mask).
  - WRAP with any other len, or reserved burst 11: treated as INCR.
- Errors:
  - pslverr affects only that beat's rresp.
  - The burst continues to completion; the beat count always equals arlen+1.
- Interface rules:
  - arready is never 1 while a burst is active; a new AR is accepted no earlier than the cycle after the last R handshake.
  - rvalid never depends combinationally on rready.
  - pwrite is always 0; pwdata is not driven by this block.

Test Plan:
- Single beat: arid=3, araddr=0x100, arlen=0, INCR; pready=1 immediately, prdata=0xDEADBEEF. Expect paddr=0x100, rvalid at AR edge+3, rid=3, rdata=0xDEADBEEF, rresp=00, rlast=1, then arready=1.
- INCR burst: araddr=0x1F8, arlen=3. Expect paddr 0x1F8, 0x1FC, 0x200, 0x204; rlast only on 4th beat; hold rready=0 for 5 cycles on beat 2 and expect R outputs stable and no APB activity.
- WRAP burst: araddr=0x3C, arlen=3. Expect paddr 0x3C, 0x30, 0x34, 0x38. FIXED burst: araddr=0x40, arlen=2. Expect paddr 0x40 three times.
- Wait states and error: pready low for 4 cycles on beat 1 with pslverr=1. Expect psel/penable held, beat 1 rresp=10; beat 2 (pslverr=0) rresp=00; 2 beats total.
- Reset mid-burst: rst=1 during ACCESS of beat 2 of 4. Expect psel=0 and rvalid=0 the next cycle, and arready=1 the first cycle after rst=0. A new single-beat read then completes normally with rid set to its own arid.
- Unaligned and edge cases: araddr=0x103, arlen=0. Expect paddr=0x100. INCR from araddr=0xFFFFFFFC, arlen=1. Expect second paddr=0x00000000.
